reg_group_mp: RTL

//  Multi-hart GPR/PC context store for the barrel-threaded core. Generalises the per-hart register group:

---
 rtl/reg_group_mp_pkg.sv | 24 ++
 rtl/reg_group_mp_hart_ctx.sv | 68 ++++++
 rtl/reg_group_mp.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_group_mp_pkg.sv
// -----------------------------------------------------------------------------
// reg_group_mp_pkg
// Shared types and helpers for the multi-hart GPR/PC context store.
//   gpr_idx_t    : 5-bit GPR index (x0..x31)
//   clr_state_e  : hart clear sequencer states
//   GPR_COUNT    : architectural GPR count
//   hart_w()     : hart index width, never narrower than one bit
// -----------------------------------------------------------------------------
package reg_group_mp_pkg;

    typedef logic [4:0] gpr_idx_t;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_e;

    localparam int GPR_COUNT = 32;

    function automatic int hart_w(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_group_mp_hart_ctx.sv
// -----------------------------------------------------------------------------
// hart_ctx
// One hart's architectural context: PC plus x1..x31, one write port for each,
// NUM_RD_PORTS independent combinational GPR read ports.
// Ports:
//   clk, rst            clock, async active-high reset
//   pc_wr_en/pc_wr_data PC write (already filtered by the top level)
//   reg_wr_en/addr/data GPR write (x0 writes are discarded here)
//   rd_addr             NUM_RD_PORTS x 5 packed read indices
//   rd_data             NUM_RD_PORTS x REG_WIDTH packed read data
//   pc                  current PC
// -----------------------------------------------------------------------------
module hart_ctx
    import reg_group_mp_pkg::*;
#(
    parameter int                   REG_WIDTH    = 32,
    parameter int                   NUM_RD_PORTS = 2,
    parameter logic [REG_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pc_wr_en,
    input  logic [REG_WIDTH-1:0]              pc_wr_data,
    input  logic                              reg_wr_en,
    input  logic [4:0]                        reg_wr_addr,
    input  logic [REG_WIDTH-1:0]              reg_wr_data,
    input  logic [NUM_RD_PORTS*5-1:0]         rd_addr,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0] rd_data,
    output logic [REG_WIDTH-1:0]              pc
);

    logic [REG_WIDTH-1:0] pc_q;
    // Entry 0 is reset to zero and never written, so x0 reads as zero through
    // the ordinary read mux and collapses to a constant in synthesis.
    logic [REG_WIDTH-1:0] gpr [GPR_COUNT];

    // NOTE: the register array is reset explicitly because a hart must come up
    // with architecturally zero GPRs; this is a flop array, not an SRAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
            for (int r = 0; r < GPR_COUNT; r++) begin
                gpr[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge
            // values, so update order inside this block does not matter.
            if (pc_wr_en) begin
                pc_q <= pc_wr_data;
            end
            if (reg_wr_en && reg_wr_addr != 5'd0) begin
                gpr[reg_wr_addr] <= reg_wr_data;
            end
        end
    end

    assign pc = pc_q;

    always_comb begin
        // NOTE: default assignment first so no path through this block can
        // leave rd_data unassigned and infer a latch.
        rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data[p*REG_WIDTH +: REG_WIDTH] = gpr[rd_addr[p*5 +: 5]];
        end
    end

endmodule

// File: rtl/reg_group_mp.sv
// -----------------------------------------------------------------------------
// reg_group_mp
// Multi-hart GPR/PC context store with a per-hart hardware clear sequencer.
// Top level owns hart decode, write dropping, the clear FSM, optional
// write-through bypass and output muxing; contexts live in hart_ctx.
// Ports:
//   clk, rst                       clock, async active-high reset
//   pc_wr_en/hart/data             PC write
//   pc_rd_hart -> pc               combinational PC read
//   reg_wr_en/hart/addr/data       GPR write
//   reg_rd_hart, reg_rd_addr       shared read hart, per-port read index
//   reg_rd_data                    per-port combinational read data
//   clr_req, clr_hart              request x1..x31 sweep of one hart
//   clr_busy, clr_busy_hart        sweep in progress / hart being swept
//   clr_done                       high in the cycle of the final sweep write
// Build option:
//   REG_GROUP_MP_BYPASS_EN  reads matching a same-cycle accepted write return
//                           the write data instead of the stored contents.
// -----------------------------------------------------------------------------
module reg_group_mp
    import reg_group_mp_pkg::*;
#(
    parameter int                   NUM_HART     = 4,
    parameter int                   REG_WIDTH    = 32,
    parameter int                   NUM_RD_PORTS = 2,
    parameter logic [REG_WIDTH-1:0] RESET_VECTOR = '0,
    localparam int                  HART_W       = hart_w(NUM_HART)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pc_wr_en,
    input  logic [HART_W-1:0]                 pc_wr_hart,
    input  logic [REG_WIDTH-1:0]              pc_wr_data,
    input  logic [HART_W-1:0]                 pc_rd_hart,
    output logic [REG_WIDTH-1:0]              pc,
    input  logic                              reg_wr_en,
    input  logic [HART_W-1:0]                 reg_wr_hart,
    input  logic [4:0]                        reg_wr_addr,
    input  logic [REG_WIDTH-1:0]              reg_wr_data,
    input  logic [HART_W-1:0]                 reg_rd_hart,
    input  logic [NUM_RD_PORTS*5-1:0]         reg_rd_addr,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0] reg_rd_data,
    input  logic                              clr_req,
    input  logic [HART_W-1:0]                 clr_hart,
    output logic                              clr_busy,
    output logic [HART_W-1:0]                 clr_busy_hart,
    output logic                              clr_done
);

    function automatic logic hart_valid(logic [HART_W-1:0] h);
        return int'(h) < NUM_HART;
    endfunction

    clr_state_e state;
    gpr_idx_t   idx;

    logic clr_accept;
    logic reg_acc;
    logic pc_acc;

    logic [NUM_RD_PORTS*REG_WIDTH-1:0] ctx_rd [NUM_HART];
    logic [REG_WIDTH-1:0]              ctx_pc [NUM_HART];

    // A hart under clear is frozen: its writes are dropped here, and a PC write
    // colliding with the clear request of the same hart loses to the clear.
    assign clr_accept = (state == CLR_IDLE) && clr_req && hart_valid(clr_hart);
    assign reg_acc    = reg_wr_en && hart_valid(reg_wr_hart) && (reg_wr_addr != 5'd0)
                        && !(clr_busy && reg_wr_hart == clr_busy_hart);
    assign pc_acc     = pc_wr_en && hart_valid(pc_wr_hart)
                        && !(clr_busy && pc_wr_hart == clr_busy_hart)
                        && !(clr_accept && pc_wr_hart == clr_hart);

    // Clear sequencer: idx walks 1..31, one zero write per cycle. clr_done is
    // registered one cycle early so it coincides with the idx==31 write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CLR_IDLE;
            idx           <= 5'd0;
            clr_busy      <= 1'b0;
            clr_busy_hart <= '0;
            clr_done      <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_accept) begin
                        state         <= CLR_SWEEP;
                        clr_busy      <= 1'b1;
                        clr_busy_hart <= clr_hart;
                        idx           <= 5'd1;
                    end
                end
                CLR_SWEEP: begin
                    idx      <= idx + 5'd1;
                    clr_done <= (idx == 5'd30);
                    if (idx == 5'd31) begin
                        state    <= CLR_IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b0;
                    end
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_HART; i++) begin : g_hart
        logic sweep_here;
        logic clr_here;

        // The swept hart's external writes are already dropped, so the sweep
        // can borrow its single write port without arbitration.
        assign sweep_here = (state == CLR_SWEEP) && (clr_busy_hart == HART_W'(i));
        assign clr_here   = clr_accept && (clr_hart == HART_W'(i));

        hart_ctx #(
            .REG_WIDTH    (REG_WIDTH),
            .NUM_RD_PORTS (NUM_RD_PORTS),
            .RESET_VECTOR (RESET_VECTOR)
        ) u_ctx (
            .clk         (clk),
            .rst         (rst),
            .pc_wr_en    (clr_here || (pc_acc && pc_wr_hart == HART_W'(i))),
            .pc_wr_data  (clr_here ? RESET_VECTOR : pc_wr_data),
            .reg_wr_en   (sweep_here || (reg_acc && reg_wr_hart == HART_W'(i))),
            .reg_wr_addr (sweep_here ? idx : reg_wr_addr),
            .reg_wr_data (sweep_here ? '0 : reg_wr_data),
            .rd_addr     (reg_rd_addr),
            .rd_data     (ctx_rd[i]),
            .pc          (ctx_pc[i])
        );
    end

    always_comb begin
        pc = '0;
        if (hart_valid(pc_rd_hart)) begin
            if (clr_busy && pc_rd_hart == clr_busy_hart) begin
                pc = RESET_VECTOR;
            end else begin
                pc = ctx_pc[pc_rd_hart];
`ifdef REG_GROUP_MP_BYPASS_EN
                if (pc_acc && pc_wr_hart == pc_rd_hart) begin
                    pc = pc_wr_data;
                end
`endif
            end
        end
    end

    always_comb begin
        reg_rd_data = '0;
        if (hart_valid(reg_rd_hart) && !(clr_busy && reg_rd_hart == clr_busy_hart)) begin
            reg_rd_data = ctx_rd[reg_rd_hart];
`ifdef REG_GROUP_MP_BYPASS_EN
            // reg_acc excludes x0, so an x0 read never picks up write data.
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (reg_acc && reg_wr_hart == reg_rd_hart
                    && reg_wr_addr == reg_rd_addr[p*5 +: 5]) begin
                    reg_rd_data[p*REG_WIDTH +: REG_WIDTH] = reg_wr_data;
                end
            end
`endif
        end
    end

endmodule
